datapath_p2: RTL and testbench
==============================

Name: datapath_p2

Overview:
- 32-bit single-bus Mini-SRC-style CPU datapath, phase 2.
- Contains: 16 general registers with Gra/Grb/Grc select-and-encode logic, PC, IR, MAR, MDR, Y, 64-bit Z, HI, LO, InPort, OutPort, ALU, and the CON branch-condition flip-flop.
- Driven cycle-by-cycle by an external control unit or bench through one-hot control strobes.

Parameters:
- WIDTH, 32, datapath and bus width.
- NREGS, 16, number of general registers (R0–R15).

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  reset; synchronous, active-low.
- outp  out  32  OutPort register contents.
- PCout, Zhiout, Zlowout, MDRout, HIout, LOout, InPortout  in  1 each  bus drive enables.
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin  in  1 each  register load enables.
- IncPC  in  1  makes the ALU compute bus+1.
- Read  in  1  selects Mdatain as the MDR source.
- Write  in  1  reserved; no internal effect.
- Gra, Grb, Grc  in  1 each  register-field selects.
- Rin, Rout  in  1 each  selected-register load / drive.
- BAout  in  1  base-address drive; R0 reads as 0.
- Cout  in  1  drives the sign-extended constant onto the bus.
- CONIn  in  1  latches the branch condition.
- Strobe  in  1  loads InPort from InPort_data.
- Mdatain  in  32  memory read data.
- InPort_data  in  32  external input-device data (last positional port).

Behaviour:
- All state updates on the rising edge of Clock.
- Clear=0 at an edge zeroes all registers: R0–R15, PC, IR, MAR, MDR, Y, Z, HI, LO, InPort, OutPort, CON. outp therefore reads 0.
- Register loads take effect at the edge where the enable is high; the new value is visible on the bus in the next cycle.

Bus:
- Combinational; driven by the single asserted source.
- Priority if several are asserted: R(selected) > HI > LO > Zhi > Zlo > PC > MDR > InPort > C. No source asserted gives 0.

Register selection:
- Field = IR[26:23] if Gra, IR[22:19] if Grb, IR[18:15] if Grc (OR of the gated fields).
- Rin loads the selected register from the bus.
- Rout or BAout drives the selected register onto the bus.
- BAout with R0 selected drives 0.

Constant and registers:
- C = IR[18:0] sign-extended to 32 bits.
- MDR loads Mdatain when Read=1, otherwise the bus.
- MAR, PC, IR, Y, HI, LO and OutPort load from the bus.

ALU (combinational, inputs Y and bus, result 64 bits into Z on Zin):
- IncPC=1: Zlo = bus+1 (takes precedence over the opcode).
- Otherwise the operation is decoded from IR[31:27]:
  - add/addi/ld/ldi/st/br: A+B.
  - sub: A−B.
  - and/andi: A&B. or/ori: A|B.
  - shr: logical right shift. shl: left shift. ror / rol: rotate right / left. Shift amount is B[4:0].
  - neg: −B. not: ~B.
  - Any other opcode: B.
- Zhi = 0 for all non-mul/div operations.

CON:
- On CONIn, latches a condition on the bus value, selected by C2 = IR[20:19]:
  - 00 brzr: bus==0.
  - 01 brnz: bus!=0.
  - 10 brpl: bus[31]==0.
  - 11 brmi: bus[31]==1.
- Holds its value otherwise.
- The control side gates PCin with CON.

Optional Feature:
- Macro MULDIV_EN.
- Defined: mul (01110) gives a signed 64-bit product {Zhi,Zlo}. div (01111) gives Zlo = signed quotient and Zhi = remainder; divide by zero yields Zlo = all ones, Zhi = dividend.
- Undefined: mul and div fall to the default (pass B, Zhi = 0).

Decomposition:
- Package datapath_p2_pkg holds:
  - opcode constants: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010.
  - branch C2 codes.
  - WIDTH.
- One sub-module: datapath_p2_alu (combinational ALU).

Test Plan:
- Clear=0 for one edge -> outp=0, PC=0, CON=0; PCout alone drives bus=0.
- Fetch: PCout+MARin+IncPC+Zin from PC=0 -> Z=1; then Zlowout+PCin+Read+MDRin with Mdatain=0x91100023 -> PC=1, MDR=0x91100023; then MDRout+IRin -> IR=0x91100023.
- brpl taken (R2=0): Gra+Rout+CONIn -> CON=1; PCout+Yin -> Y=1; Cout+Zin -> Z=36; Zlowout+PCin -> PC=36.
- brpl not taken: R2=0x80000000 -> CON=0; Z still 36, and PC stays 1 when PCin is gated by CON.
- BAout with IR[26:23]=0 and R0=0x55 -> bus=0; Rout in the same setup -> bus=0x55.
- add: IR opcode 00011, Y=7, bus=5 -> Zlo=12. ror by 1 of 0x00000001 -> 0x80000000. With MULDIV_EN: mul −2×3 -> {Zhi,Zlo} = 0xFFFFFFFF_FFFFFFFA.

Source files
------------

// File: rtl/datapath_p2_pkg.sv
// Shared constants for the phase-2 Mini-SRC datapath: bus width, register count,
// instruction opcodes and branch condition codes.
package datapath_p2_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREGS = 16;

    typedef enum logic [4:0] {
        OpLd   = 5'b00000,
        OpLdi  = 5'b00001,
        OpSt   = 5'b00010,
        OpAdd  = 5'b00011,
        OpSub  = 5'b00100,
        OpAnd  = 5'b00101,
        OpOr   = 5'b00110,
        OpShr  = 5'b00111,
        OpShl  = 5'b01000,
        OpRor  = 5'b01001,
        OpRol  = 5'b01010,
        OpAddi = 5'b01011,
        OpAndi = 5'b01100,
        OpOri  = 5'b01101,
        OpMul  = 5'b01110,
        OpDiv  = 5'b01111,
        OpNeg  = 5'b10000,
        OpNot  = 5'b10001,
        OpBr   = 5'b10010
    } opcode_e;

    typedef enum logic [1:0] {
        BrZr = 2'b00,
        BrNz = 2'b01,
        BrPl = 2'b10,
        BrMi = 2'b11
    } c2_e;

endpackage

// File: rtl/datapath_p2_alu.sv
// Combinational ALU: A comes from Y, B from the bus, 64-bit result split into hi/lo.
// Multiply and divide exist only when MULDIV_EN is defined.
module datapath_p2_alu
    import datapath_p2_pkg::*;
(
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [4:0]       opcode_i,
    input  logic             inc_pc_i,
    output logic [WIDTH-1:0] z_hi_o,
    output logic [WIDTH-1:0] z_lo_o
);

    logic [4:0]         shamt;
    logic [2*WIDTH-1:0] rot_r;
    logic [2*WIDTH-1:0] rot_l;
`ifdef MULDIV_EN
    logic signed [2*WIDTH-1:0] prod;
`endif

    assign shamt = b_i[4:0];
    // Rotates shift a doubled copy so the wrapped bits fall into the kept half.
    assign rot_r = {a_i, a_i} >> shamt;
    assign rot_l = {a_i, a_i} << shamt;

    always_comb begin
        z_hi_o = '0;
        z_lo_o = b_i;
`ifdef MULDIV_EN
        prod   = '0;
`endif
        if (inc_pc_i) begin
            z_lo_o = b_i + WIDTH'(1);
        end else begin
            case (opcode_i)
                OpAdd, OpAddi, OpLd, OpLdi, OpSt, OpBr: z_lo_o = a_i + b_i;
                OpSub:         z_lo_o = a_i - b_i;
                OpAnd, OpAndi: z_lo_o = a_i & b_i;
                OpOr, OpOri:   z_lo_o = a_i | b_i;
                OpShr:         z_lo_o = a_i >> shamt;
                OpShl:         z_lo_o = a_i << shamt;
                OpRor:         z_lo_o = rot_r[WIDTH-1:0];
                OpRol:         z_lo_o = rot_l[2*WIDTH-1:WIDTH];
                OpNeg:         z_lo_o = -b_i;
                OpNot:         z_lo_o = ~b_i;
`ifdef MULDIV_EN
                OpMul: begin
                    prod = $signed({{WIDTH{a_i[WIDTH-1]}}, a_i})
                         * $signed({{WIDTH{b_i[WIDTH-1]}}, b_i});
                    {z_hi_o, z_lo_o} = prod;
                end
                OpDiv: begin
                    if (b_i == '0) begin
                        z_lo_o = '1;
                        z_hi_o = a_i;
                    end else begin
                        z_lo_o = $signed(a_i) / $signed(b_i);
                        z_hi_o = $signed(a_i) % $signed(b_i);
                    end
                end
`endif
                default:       z_lo_o = b_i;
            endcase
        end
    end

endmodule

// File: rtl/datapath_p2.sv
// Single-bus Mini-SRC datapath, phase 2: register file, special registers, ALU and CON.
// Define MULDIV_EN to enable signed multiply/divide in the ALU.
module datapath_p2
    import datapath_p2_pkg::*;
(
    input  logic             Clock,
    input  logic             Clear,
    output logic [WIDTH-1:0] outp,
    input  logic             PCout,
    input  logic             Zhiout,
    input  logic             Zlowout,
    input  logic             MDRout,
    input  logic             HIout,
    input  logic             LOout,
    input  logic             InPortout,
    input  logic             MARin,
    input  logic             Zin,
    input  logic             PCin,
    input  logic             MDRin,
    input  logic             IRin,
    input  logic             Yin,
    input  logic             HIin,
    input  logic             LOin,
    input  logic             OutPortin,
    input  logic             IncPC,
    input  logic             Read,
    input  logic             Write,
    input  logic             Gra,
    input  logic             Grb,
    input  logic             Grc,
    input  logic             Rin,
    input  logic             Rout,
    input  logic             BAout,
    input  logic             Cout,
    input  logic             CONIn,
    input  logic             Strobe,
    input  logic [WIDTH-1:0] Mdatain,
    input  logic [WIDTH-1:0] InPort_data
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] pc_q, ir_q, mar_q, mdr_q, y_q, zhi_q, zlo_q;
    logic [WIDTH-1:0] hi_q, lo_q, inport_q, outport_q;
    logic             con_q;

    logic [3:0]       reg_sel;
    logic [WIDTH-1:0] c_sext;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_hi, alu_lo;
    logic             cond;
    logic             unused_ok;

    assign reg_sel = ({4{Gra}} & ir_q[26:23])
                   | ({4{Grb}} & ir_q[22:19])
                   | ({4{Grc}} & ir_q[18:15]);
    assign c_sext  = {{(WIDTH-19){ir_q[18]}}, ir_q[18:0]};

    // Fixed-priority bus; BAout on R0 reads as zero for base+offset addressing.
    always_comb begin
        bus = '0;
        if (Rout || BAout) begin
            bus = (BAout && reg_sel == 4'd0) ? '0 : regs_q[reg_sel];
        end else if (HIout) begin
            bus = hi_q;
        end else if (LOout) begin
            bus = lo_q;
        end else if (Zhiout) begin
            bus = zhi_q;
        end else if (Zlowout) begin
            bus = zlo_q;
        end else if (PCout) begin
            bus = pc_q;
        end else if (MDRout) begin
            bus = mdr_q;
        end else if (InPortout) begin
            bus = inport_q;
        end else if (Cout) begin
            bus = c_sext;
        end
    end

    datapath_p2_alu u_alu (
        .a_i      (y_q),
        .b_i      (bus),
        .opcode_i (ir_q[31:27]),
        .inc_pc_i (IncPC),
        .z_hi_o   (alu_hi),
        .z_lo_o   (alu_lo)
    );

    always_comb begin
        cond = 1'b0;
        case (c2_e'(ir_q[20:19]))
            BrZr:    cond = (bus == '0);
            BrNz:    cond = (bus != '0);
            BrPl:    cond = ~bus[WIDTH-1];
            BrMi:    cond = bus[WIDTH-1];
            default: cond = 1'b0;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            pc_q      <= '0;
            ir_q      <= '0;
            mar_q     <= '0;
            mdr_q     <= '0;
            y_q       <= '0;
            zhi_q     <= '0;
            zlo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            inport_q  <= '0;
            outport_q <= '0;
            con_q     <= 1'b0;
        end else begin
            if (Rin)       regs_q[reg_sel] <= bus;
            if (PCin)      pc_q      <= bus;
            if (IRin)      ir_q      <= bus;
            if (MARin)     mar_q     <= bus;
            if (MDRin)     mdr_q     <= Read ? Mdatain : bus;
            if (Yin)       y_q       <= bus;
            if (HIin)      hi_q      <= bus;
            if (LOin)      lo_q      <= bus;
            if (OutPortin) outport_q <= bus;
            if (Strobe)    inport_q  <= InPort_data;
            if (CONIn)     con_q     <= cond;
            if (Zin) begin
                zhi_q <= alu_hi;
                zlo_q <= alu_lo;
            end
        end
    end

    assign outp = outport_q;

    // MAR feeds the memory interface of a later phase; Write is reserved.
    assign unused_ok = ^{Write, mar_q};

endmodule

// File: tb/tb_datapath_p2.sv
// Self-checking bench for datapath_p2: directed micro-op sequences, then random strobes
// compared against a behavioural model of the register transfers.
module tb_datapath_p2;
    import datapath_p2_pkg::*;

    typedef struct packed {
        logic pc_out, zhi_out, zlo_out, mdr_out, hi_out, lo_out, inport_out;
        logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outport_in;
        logic inc_pc, read, write, gra, grb, grc, r_in, r_out, ba_out, c_out, con_in, strobe;
    } ctl_t;

    logic        Clock = 1'b0;
    logic        Clear = 1'b0;
    logic [31:0] outp;
    logic [31:0] Mdatain = '0;
    logic [31:0] InPort_data = '0;
    ctl_t        ctl = '0;

    // Model state
    logic [31:0] m_r [16];
    logic [31:0] m_pc, m_ir, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo, m_in, m_out;
    logic        m_con;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    datapath_p2 dut (
        .Clock       (Clock),
        .Clear       (Clear),
        .outp        (outp),
        .PCout       (ctl.pc_out),
        .Zhiout      (ctl.zhi_out),
        .Zlowout     (ctl.zlo_out),
        .MDRout      (ctl.mdr_out),
        .HIout       (ctl.hi_out),
        .LOout       (ctl.lo_out),
        .InPortout   (ctl.inport_out),
        .MARin       (ctl.mar_in),
        .Zin         (ctl.z_in),
        .PCin        (ctl.pc_in),
        .MDRin       (ctl.mdr_in),
        .IRin        (ctl.ir_in),
        .Yin         (ctl.y_in),
        .HIin        (ctl.hi_in),
        .LOin        (ctl.lo_in),
        .OutPortin   (ctl.outport_in),
        .IncPC       (ctl.inc_pc),
        .Read        (ctl.read),
        .Write       (ctl.write),
        .Gra         (ctl.gra),
        .Grb         (ctl.grb),
        .Grc         (ctl.grc),
        .Rin         (ctl.r_in),
        .Rout        (ctl.r_out),
        .BAout       (ctl.ba_out),
        .Cout        (ctl.c_out),
        .CONIn       (ctl.con_in),
        .Strobe      (ctl.strobe),
        .Mdatain     (Mdatain),
        .InPort_data (InPort_data)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ref_field();
        logic [3:0] f = 4'd0;
        if (ctl.gra) f = f | m_ir[26:23];
        if (ctl.grb) f = f | m_ir[22:19];
        if (ctl.grc) f = f | m_ir[18:15];
        return f;
    endfunction

    function automatic logic [31:0] ref_bus();
        logic [3:0] f = ref_field();
        if (ctl.ba_out && f == 4'd0) return 32'd0;
        if (ctl.r_out || ctl.ba_out) return m_r[f];
        if (ctl.hi_out)     return m_hi;
        if (ctl.lo_out)     return m_lo;
        if (ctl.zhi_out)    return m_zhi;
        if (ctl.zlo_out)    return m_zlo;
        if (ctl.pc_out)     return m_pc;
        if (ctl.mdr_out)    return m_mdr;
        if (ctl.inport_out) return m_in;
        if (ctl.c_out)      return 32'($signed(m_ir[18:0]));
        return 32'd0;
    endfunction

    function automatic logic [63:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] op, input logic inc);
        logic [31:0] r = b;
        int          n = int'(b[4:0]);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        if (inc) return {32'd0, b + 32'd1};
        case (op)
            OpAdd, OpAddi, OpLd, OpLdi, OpSt, OpBr: r = a + b;
            OpSub:         r = a - b;
            OpAnd, OpAndi: r = a & b;
            OpOr, OpOri:   r = a | b;
            OpShr:         r = a >> n;
            OpShl:         r = a << n;
            OpRor: begin r = a; repeat (n) r = {r[0], r[31:1]}; end
            OpRol: begin r = a; repeat (n) r = {r[30:0], r[31]}; end
            OpNeg:         r = 32'd0 - b;
            OpNot:         r = ~b;
`ifdef MULDIV_EN
            OpMul:         return 64'(sa * sb);
            OpDiv: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {32'(sa % sb), 32'(sa / sb)};
            end
`endif
            default:       r = b;
        endcase
        return {32'd0, r};
    endfunction

    function automatic logic ref_cond(input logic [31:0] b);
        case (m_ir[20:19])
            2'b00:   return b == 32'd0;
            2'b01:   return b != 32'd0;
            2'b10:   return !b[31];
            default: return b[31];
        endcase
    endfunction

    // One clock with the current strobes: check the bus, then advance the model.
    task automatic step();
        logic [31:0] b;
        logic [63:0] z;
        logic [3:0]  f;
        logic        c;
        #1;
        b = ref_bus();
        f = ref_field();
        z = ref_alu(m_y, b, m_ir[31:27], ctl.inc_pc);
        c = ref_cond(b);
        check_eq("bus", dut.bus, b);
        @(posedge Clock);
        if (!Clear) begin
            foreach (m_r[i]) m_r[i] = '0;
            {m_pc, m_ir, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo, m_in, m_out} = '0;
            m_con = 1'b0;
        end else begin
            if (ctl.r_in)       m_r[f] = b;
            if (ctl.pc_in)      m_pc   = b;
            if (ctl.ir_in)      m_ir   = b;
            if (ctl.mdr_in)     m_mdr  = ctl.read ? Mdatain : b;
            if (ctl.y_in)       m_y    = b;
            if (ctl.hi_in)      m_hi   = b;
            if (ctl.lo_in)      m_lo   = b;
            if (ctl.outport_in) m_out  = b;
            if (ctl.strobe)     m_in   = InPort_data;
            if (ctl.con_in)     m_con  = c;
            if (ctl.z_in)       {m_zhi, m_zlo} = z;
        end
        #1;
        check_eq("outp", outp, m_out);
        check_eq("con", dut.con_q, m_con);
    endtask

    task automatic go(input ctl_t c);
        ctl = c;
        step();
    endtask

    task automatic peek(input ctl_t c, input string tag, input logic [31:0] exp);
        ctl = c;
        #1;
        check_eq(tag, dut.bus, exp);
    endtask

    task automatic load_mdr(input logic [31:0] v);
        Mdatain = v;
        go(ctl_t'{read: 1'b1, mdr_in: 1'b1, default: 1'b0});
    endtask

    task automatic load_ir(input logic [31:0] v);
        load_mdr(v);
        go(ctl_t'{mdr_out: 1'b1, ir_in: 1'b1, default: 1'b0});
    endtask

    // Branch sequence; PCin is gated by the model's CON as a control unit would.
    task automatic branch(input string tag, input logic exp_con, input logic [31:0] exp_pc);
        ctl_t c;
        go(ctl_t'{gra: 1'b1, r_out: 1'b1, con_in: 1'b1, default: 1'b0});
        check_eq({tag, "_con"}, dut.con_q, exp_con);
        go(ctl_t'{pc_out: 1'b1, y_in: 1'b1, default: 1'b0});
        go(ctl_t'{c_out: 1'b1, z_in: 1'b1, default: 1'b0});
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, {tag, "_z"}, 32'd36);
        c = ctl_t'{zlo_out: 1'b1, default: 1'b0};
        c.pc_in = m_con;
        go(c);
        peek(ctl_t'{pc_out: 1'b1, default: 1'b0}, {tag, "_pc"}, exp_pc);
    endtask

    task automatic alu_op(input logic [4:0] op, input logic [31:0] y, input logic [31:0] b);
        load_ir({op, 27'd0});
        load_mdr(y);
        go(ctl_t'{mdr_out: 1'b1, y_in: 1'b1, default: 1'b0});
        load_mdr(b);
        go(ctl_t'{mdr_out: 1'b1, z_in: 1'b1, default: 1'b0});
    endtask

    initial begin
        foreach (m_r[i]) m_r[i] = '0;
        {m_pc, m_ir, m_mdr, m_y, m_zhi, m_zlo, m_hi, m_lo, m_in, m_out} = '0;
        m_con = 1'b0;

        // Reset
        Clear = 1'b0;
        go('0);
        Clear = 1'b1;
        check_eq("clear_outp", outp, 32'd0);
        check_eq("clear_con", dut.con_q, 1'b0);
        peek(ctl_t'{pc_out: 1'b1, default: 1'b0}, "clear_pc", 32'd0);

        // Fetch
        go(ctl_t'{pc_out: 1'b1, mar_in: 1'b1, inc_pc: 1'b1, z_in: 1'b1, default: 1'b0});
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, "fetch_z", 32'd1);
        Mdatain = 32'h9110_0023;
        go(ctl_t'{zlo_out: 1'b1, pc_in: 1'b1, read: 1'b1, mdr_in: 1'b1, default: 1'b0});
        peek(ctl_t'{pc_out: 1'b1, default: 1'b0}, "fetch_pc", 32'd1);
        peek(ctl_t'{mdr_out: 1'b1, default: 1'b0}, "fetch_mdr", 32'h9110_0023);
        go(ctl_t'{mdr_out: 1'b1, ir_in: 1'b1, default: 1'b0});
        peek(ctl_t'{c_out: 1'b1, default: 1'b0}, "ir_const", 32'h23);

        // brpl taken with R2 = 0
        branch("brpl_taken", 1'b1, 32'd36);

        // brpl not taken: R2 = 0x80000000, PC back to 1
        load_mdr(32'h8000_0000);
        go(ctl_t'{mdr_out: 1'b1, gra: 1'b1, r_in: 1'b1, default: 1'b0});
        load_mdr(32'd1);
        go(ctl_t'{mdr_out: 1'b1, pc_in: 1'b1, default: 1'b0});
        branch("brpl_not", 1'b0, 32'd1);

        // BAout on R0 versus Rout on R0
        load_ir({OpAdd, 4'd0, 4'd1, 4'd2, 15'd0});
        load_mdr(32'h55);
        go(ctl_t'{mdr_out: 1'b1, gra: 1'b1, r_in: 1'b1, default: 1'b0});
        peek(ctl_t'{gra: 1'b1, ba_out: 1'b1, default: 1'b0}, "baout_r0", 32'd0);
        peek(ctl_t'{gra: 1'b1, r_out: 1'b1, default: 1'b0}, "rout_r0", 32'h55);

        // ALU spot checks
        alu_op(OpAdd, 32'd7, 32'd5);
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, "add_lo", 32'd12);
        peek(ctl_t'{zhi_out: 1'b1, default: 1'b0}, "add_hi", 32'd0);
        alu_op(OpRor, 32'd1, 32'd1);
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, "ror_lo", 32'h8000_0000);
        alu_op(OpSub, 32'd3, 32'd5);
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, "sub_lo", 32'hFFFF_FFFE);
        alu_op(OpMul, 32'hFFFF_FFFE, 32'd3);
`ifdef MULDIV_EN
        peek(ctl_t'{zhi_out: 1'b1, default: 1'b0}, "mul_hi", 32'hFFFF_FFFF);
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, "mul_lo", 32'hFFFF_FFFA);
`else
        peek(ctl_t'{zhi_out: 1'b1, default: 1'b0}, "mul_hi", 32'd0);
        peek(ctl_t'{zlo_out: 1'b1, default: 1'b0}, "mul_lo", 32'd3);
`endif
        go(ctl_t'{zlo_out: 1'b1, outport_in: 1'b1, default: 1'b0});
        check_eq("outport", outp, m_out);

        // Random strobes, including overlapping bus sources and occasional clears
        for (int i = 0; i < 600; i++) begin
            Clear       = ($urandom_range(0, 59) != 0);
            Mdatain     = $urandom;
            InPort_data = $urandom;
            ctl         = ctl_t'(28'($urandom & $urandom & $urandom));
            if ($urandom_range(0, 3) == 0) ctl.ir_in = 1'b1;
            step();
        end
        Clear = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
